// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Purpose:
//   Steps the AES-128 decryption datapath through its schedule: one initial
//   AddRoundKey load (key index NUM_ROUNDS), then inverse rounds NUM_ROUNDS-1
//   down to 1, then the final round (key index 0, no InvMixColumns).
//   Each step fires either on every clock or on a programmable divided tick.
//   The tick is a clock enable inside the single clk domain, not a derived
//   clock, so the sequence can be slowed down enough to watch on a board.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   request a decryption (accepted only when idle)
//   abort      in   synchronous cancel back to idle
//   slow_mode  in   1 = pace steps by the divided tick, 0 = every clock
//   div_limit  in   tick period minus 1 (slow mode), latched at start
//   busy       out  high from the cycle after start through the done cycle
//   load_state out  1-cycle pulse: load ciphertext + AddRoundKey(k[NUM_ROUNDS])
//   round_en   out  1-cycle pulse: execute one inverse round
//   last_round out  qualifies round_en on the final round
//   round_idx  out  round-key index for the current or next pulse
//   done       out  1-cycle pulse when the plaintext is valid
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int DIV_W      = 10,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             slow_mode,
    input  logic [DIV_W-1:0] div_limit,
    output logic             busy,
    output logic             load_state,
    output logic             round_en,
    output logic             last_round,
    output logic [3:0]       round_idx,
    output logic             done
);

    localparam logic [3:0] FIRST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             slow_q, slow_d;
    logic [DIV_W-1:0] limit_q, limit_d;

    logic active;
    logic tick;

    // Pacing only runs in the states that wait for a step; DONE is unpaced.
    assign active = (state_q == LOAD) || (state_q == ROUND) || (state_q == FINAL);
    // With limit 0 the compare is always true, so slow mode degenerates to fast.
    assign tick   = active && (!slow_q || (cnt_q == limit_q));

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        slow_d     = slow_q;
        limit_d    = limit_q;
        load_state = 1'b0;
        round_en   = 1'b0;
        last_round = 1'b0;
        done       = 1'b0;

        if (active && slow_q) begin
            cnt_d = (cnt_q == limit_q) ? '0 : cnt_q + DIV_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                // abort wins over a simultaneous start.
                if (start && !abort) begin
                    slow_d  = slow_mode;
                    limit_d = div_limit;
                    cnt_d   = '0;
                    idx_d   = FIRST_IDX;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (tick) begin
                    load_state = 1'b1;
                    idx_d      = FIRST_IDX - 4'd1;
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                if (tick) begin
                    round_en = 1'b1;
                    if (idx_q == 4'd1) begin
                        idx_d   = 4'd0;
                        state_d = FINAL;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            FINAL: begin
                if (tick) begin
                    round_en   = 1'b1;
                    last_round = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the busy state decided, including the
        // pulses of this very cycle.
        if (abort && (state_q != IDLE)) begin
            load_state = 1'b0;
            round_en   = 1'b0;
            last_round = 1'b0;
            done       = 1'b0;
            cnt_d      = '0;
            idx_d      = 4'd0;
            state_d    = IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            slow_q  <= 1'b0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            slow_q  <= slow_d;
            limit_q <= limit_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign round_idx = idx_q;

endmodule
